// File: rtl/boot_loader.sv
// Framed byte-stream program loader for the MIPS instruction memory.
// Holds the core in reset until a checksum-valid image is written.
module boot_loader #(
  parameter int MAX_WORDS = 256,
  parameter int AW        = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          imem_wena,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          core_reset_n,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] HDR = 8'hA5;

  state_e          state_q, state_d;
  logic [7:0]      hi_q, hi_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     widx_q, widx_d;
  logic [1:0]      bidx_q, bidx_d;
  logic [23:0]     word_q, word_d;
  logic [7:0]      csum_q, csum_d;
  logic            wena_q, wena_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            crst_q, crst_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            xfer;
  logic [15:0]     count_w;

  assign rx_ready     = (state_q != S_DONE);
  assign xfer         = rx_valid && rx_ready;
  assign count_w      = {hi_q, rx_data};
  assign imem_wena    = wena_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign core_reset_n = crst_q;
  assign done         = done_q;
  assign error        = err_q;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    csum_d  = csum_q;
    wena_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    crst_d  = crst_q;
    done_d  = done_q;
    err_d   = err_q;
    if (xfer) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == HDR) state_d = S_CNT_HI;
        end
        S_CNT_HI: begin
          hi_d    = rx_data;
          state_d = S_CNT_LO;
        end
        S_CNT_LO: begin
          cnt_d  = count_w;
          widx_d = '0;
          bidx_d = '0;
          csum_d = '0;
          if (count_w == 16'd0) begin
            state_d = S_CSUM;
          end else if (count_w > 16'(MAX_WORDS)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          word_d = {word_q[15:0], rx_data};
          csum_d = csum_q ^ rx_data;
          bidx_d = bidx_q + 2'd1;
          // 4th byte completes the word; strobe it next cycle
          if (bidx_q == 2'd3) begin
            wena_d  = 1'b1;
            wdata_d = {word_q, rx_data};
            waddr_d = AW'(widx_q);
            widx_d  = widx_q + 16'd1;
            if (widx_q + 16'd1 == cnt_q) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
            crst_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        S_ERR: begin
          if (rx_data == HDR) begin
            state_d = S_CNT_HI;
            err_d   = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      wena_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      crst_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      wena_q  <= wena_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
